// File: rtl/ex_stage_if.sv
// Operand bundle from ID/EX and the EX/MEM result bundle of the execute stage.
// The master side is the surrounding pipeline; the slave side is ex_stage.
interface ex_stage_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REGW  = 3
) ();

  // ID/EX side
  logic             in_valid;
  logic [WIDTH-1:0] r1;
  logic [WIDTH-1:0] r2;
  logic [WIDTH-1:0] const_disp;
  logic [REGW-1:0]  sc;
  logic [REGW-1:0]  dest;
  logic [2:0]       alu_function;
  logic             alu_input_b_sel;
  logic             dm_mem_write;
  logic             flush;

  // EX/MEM side and flags
  logic             ex_busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic [WIDTH-1:0] out_store_data;
  logic [REGW-1:0]  out_dest;
  logic             out_mem_write;
  logic             out_reg_write;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output in_valid, r1, r2, const_disp, sc, dest, alu_function, alu_input_b_sel,
           dm_mem_write, flush,
    input  ex_busy, out_valid, out_result, out_store_data, out_dest, out_mem_write,
           out_reg_write, flag_z, flag_c
  );

  modport slave (
    input  in_valid, r1, r2, const_disp, sc, dest, alu_function, alu_input_b_sel,
           dm_mem_write, flush,
    output ex_busy, out_valid, out_result, out_store_data, out_dest, out_mem_write,
           out_reg_write, flag_z, flag_c
  );

endinterface

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a bit-serial shifter that stalls upstream via ex_busy,
// feeding the EX/MEM register and the Z/C flag register.
module ex_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REGW  = 3
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  localparam logic [2:0] FnAdd  = 3'b000;
  localparam logic [2:0] FnSub  = 3'b001;
  localparam logic [2:0] FnAnd  = 3'b010;
  localparam logic [2:0] FnOr   = 3'b011;
  localparam logic [2:0] FnXor  = 3'b100;
  localparam logic [2:0] FnShl  = 3'b101;
  localparam logic [2:0] FnShr  = 3'b110;
  localparam logic [2:0] FnPass = 3'b111;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [REGW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [REGW-1:0]  dest_q, dest_d;
  logic             valid_q, valid_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             is_shift;
  logic             shift_left;
  logic             multi_cycle;
  logic [WIDTH-1:0] step_src;
  logic [WIDTH-1:0] step_res;
  logic             step_out;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_flags_upd;
  logic             busy;

  assign op_a = bus.r1;
  assign op_b = bus.alu_input_b_sel ? bus.const_disp : bus.r2;
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  assign is_shift    = (bus.alu_function == FnShl) || (bus.alu_function == FnShr);
  assign shift_left  = (bus.alu_function == FnShl);
  assign multi_cycle = is_shift && (bus.sc > REGW'(1));

  // One-bit shift step; after the first cycle the captured accumulator is the source.
  assign step_src = (state_q == StShift) ? acc_q : op_a;
  assign step_res = shift_left ? {step_src[WIDTH-2:0], 1'b0} : {1'b0, step_src[WIDTH-1:1]};
  assign step_out = shift_left ? step_src[WIDTH-1] : step_src[0];

  // Single-cycle result (non-shift ops and shifts by 0 or 1).
  always_comb begin
    alu_res       = '0;
    alu_c         = c_q;
    alu_flags_upd = 1'b1;
    case (bus.alu_function)
      FnAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      FnSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
      end
      FnAnd: begin
        alu_res = op_a & op_b;
        alu_c   = 1'b0;
      end
      FnOr: begin
        alu_res = op_a | op_b;
        alu_c   = 1'b0;
      end
      FnXor: begin
        alu_res = op_a ^ op_b;
        alu_c   = 1'b0;
      end
      FnShl, FnShr: begin
        if (bus.sc == '0) begin
          alu_res = op_a;
        end else begin
          alu_res = step_res;
          alu_c   = step_out;
        end
      end
      FnPass: begin
        alu_res       = op_b;
        alu_flags_upd = 1'b0;
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    store_d     = store_q;
    dest_d      = dest_q;
    valid_d     = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    z_d         = z_q;
    c_d         = c_q;
    busy        = 1'b0;

    if (bus.flush) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      if (cnt_q > REGW'(1)) begin
        busy  = 1'b1;
        acc_d = step_res;
        cnt_d = cnt_q - REGW'(1);
      end else begin
        // Final step commits; upstream has held the instruction fields stable.
        state_d     = StIdle;
        cnt_d       = '0;
        result_d    = step_res;
        store_d     = bus.r2;
        dest_d      = bus.dest;
        valid_d     = 1'b1;
        mem_write_d = bus.dm_mem_write;
        reg_write_d = ~bus.dm_mem_write;
        z_d         = (step_res == '0);
        c_d         = step_out;
      end
    end else if (bus.in_valid) begin
      if (multi_cycle) begin
        busy    = 1'b1;
        acc_d   = step_res;
        cnt_d   = bus.sc - REGW'(1);
        state_d = StShift;
      end else begin
        result_d    = alu_res;
        store_d     = bus.r2;
        dest_d      = bus.dest;
        valid_d     = 1'b1;
        mem_write_d = bus.dm_mem_write;
        reg_write_d = ~bus.dm_mem_write;
        if (alu_flags_upd) begin
          z_d = (alu_res == '0);
          c_d = alu_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      store_q     <= '0;
      dest_q      <= '0;
      valid_q     <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      store_q     <= store_d;
      dest_q      <= dest_d;
      valid_q     <= valid_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      z_q         <= z_d;
      c_q         <= c_d;
    end
  end

  // Gated by reset so a held shift request cannot stall upstream while in reset.
  assign bus.ex_busy        = busy & rst;
  assign bus.out_valid      = valid_q;
  assign bus.out_result     = result_q;
  assign bus.out_store_data = store_q;
  assign bus.out_dest       = dest_q;
  assign bus.out_mem_write  = mem_write_q;
  assign bus.out_reg_write  = reg_write_q;
  assign bus.flag_z         = z_q;
  assign bus.flag_c         = c_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expected EX/MEM entries, a
// negedge monitor pops and compares on every out_valid.
module tb_ex_stage;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned REGW  = 3;

  localparam logic [2:0] FnAdd  = 3'b000;
  localparam logic [2:0] FnSub  = 3'b001;
  localparam logic [2:0] FnAnd  = 3'b010;
  localparam logic [2:0] FnOr   = 3'b011;
  localparam logic [2:0] FnXor  = 3'b100;
  localparam logic [2:0] FnShl  = 3'b101;
  localparam logic [2:0] FnShr  = 3'b110;
  localparam logic [2:0] FnPass = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_stage_if #(.WIDTH(WIDTH), .REGW(REGW)) bus ();

  ex_stage #(.WIDTH(WIDTH), .REGW(REGW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] result;
    logic [7:0] store;
    logic [2:0] dest;
    logic       mw;
    logic       rw;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_busy"}, 32'(bus.ex_busy), 0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_out_result"}, 32'(bus.out_result), 0);
    check({tag, "_out_store_data"}, 32'(bus.out_store_data), 0);
    check({tag, "_out_dest"}, 32'(bus.out_dest), 0);
    check({tag, "_out_mem_write"}, 32'(bus.out_mem_write), 0);
    check({tag, "_out_reg_write"}, 32'(bus.out_reg_write), 0);
    check({tag, "_flag_z"}, 32'(bus.flag_z), 0);
    check({tag, "_flag_c"}, 32'(bus.flag_c), 0);
  endtask

  // Drive one instruction, hold it while ex_busy, and queue its expected commit.
  task automatic issue(input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b2,
                       input logic [7:0] cd, input logic bsel, input logic [2:0] sc,
                       input logic [2:0] dst, input logic mw, input logic [7:0] res,
                       input logic z, input logic c, input int busy_exp);
    exp_t e;
    int   n;
    logic b;
    e.result = res;
    e.store  = b2;
    e.dest   = dst;
    e.mw     = mw;
    e.rw     = ~mw;
    e.z      = z;
    e.c      = c;
    sb.push_back(e);
    bus.in_valid        = 1'b1;
    bus.alu_function    = fn;
    bus.r1              = a;
    bus.r2              = b2;
    bus.const_disp      = cd;
    bus.alu_input_b_sel = bsel;
    bus.sc              = sc;
    bus.dest            = dst;
    bus.dm_mem_write    = mw;
    bus.flush           = 1'b0;
    n = 0;
    do begin
      #1 b = bus.ex_busy;
      @(posedge clk);
      #1;
      if (b) begin
        n++;
        check("bubble_out_valid", 32'(bus.out_valid), 0);
      end
    end while (b && n < 40);
    bus.in_valid = 1'b0;
    check("busy_cycles", 32'(n), 32'(busy_exp));
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_commit: got out_valid=1 result=0x%0h, expected no commit",
                   bus.out_result);
        end else begin
          e = sb.pop_front();
          check("out_result", 32'(bus.out_result), 32'(e.result));
          check("out_store_data", 32'(bus.out_store_data), 32'(e.store));
          check("out_dest", 32'(bus.out_dest), 32'(e.dest));
          check("out_mem_write", 32'(bus.out_mem_write), 32'(e.mw));
          check("out_reg_write", 32'(bus.out_reg_write), 32'(e.rw));
          check("flag_z", 32'(bus.flag_z), 32'(e.z));
          check("flag_c", 32'(bus.flag_c), 32'(e.c));
        end
      end
    end
  end

  initial begin
    bus.in_valid        = 1'b0;
    bus.r1              = '0;
    bus.r2              = '0;
    bus.const_disp      = '0;
    bus.sc              = '0;
    bus.dest            = '0;
    bus.alu_function    = '0;
    bus.alu_input_b_sel = 1'b0;
    bus.dm_mem_write    = 1'b0;
    bus.flush           = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    rst = 1'b1;

    // Load non-zero state, start a long shift, then reset mid-shift
    issue(FnAdd, 8'hFF, 8'h01, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    bus.in_valid     = 1'b1;
    bus.alu_function = FnShl;
    bus.r1           = 8'h81;
    bus.r2           = 8'h5C;
    bus.sc           = 3'd7;
    bus.dest         = 3'd2;
    @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(bus.ex_busy), 1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ADD with carry out
    issue(FnAdd, 8'hF0, 8'h20, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0, 8'h10, 1'b0, 1'b1, 0);
    // SUB equal operands via immediate; XOR to zero; SUB with borrow
    issue(FnSub, 8'h05, 8'h33, 8'h05, 1'b1, 3'd0, 3'd2, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    issue(FnXor, 8'hAA, 8'h11, 8'hAA, 1'b1, 3'd0, 3'd3, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    issue(FnSub, 8'h03, 8'h04, 8'h00, 1'b0, 3'd0, 3'd3, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    // Logic ops clear a set carry
    issue(FnAdd, 8'h80, 8'h90, 8'h00, 1'b0, 3'd0, 3'd4, 1'b0, 8'h10, 1'b0, 1'b1, 0);
    issue(FnAnd, 8'hF0, 8'h3C, 8'h00, 1'b0, 3'd0, 3'd4, 1'b0, 8'h30, 1'b0, 1'b0, 0);
    issue(FnOr,  8'h0F, 8'h00, 8'h30, 1'b1, 3'd0, 3'd4, 1'b0, 8'h3F, 1'b0, 1'b0, 0);
    // PASS leaves Z=1/C=1 untouched
    issue(FnAdd, 8'h80, 8'h80, 8'h00, 1'b0, 3'd0, 3'd5, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    issue(FnPass, 8'h12, 8'h00, 8'h7E, 1'b1, 3'd0, 3'd5, 1'b0, 8'h7E, 1'b1, 1'b1, 0);

    // Multi-cycle SHL, then back-to-back ADD
    issue(FnShl, 8'h81, 8'h00, 8'h00, 1'b0, 3'd3, 3'd5, 1'b0, 8'h08, 1'b0, 1'b0, 2);
    issue(FnAdd, 8'h01, 8'h02, 8'h00, 1'b0, 3'd0, 3'd6, 1'b0, 8'h03, 1'b0, 1'b0, 0);
    // SHR to zero, then shift boundaries sc=0 and sc=1
    issue(FnShr, 8'h03, 8'h00, 8'h00, 1'b0, 3'd2, 3'd6, 1'b0, 8'h00, 1'b1, 1'b1, 1);
    issue(FnShl, 8'h5A, 8'h00, 8'h00, 1'b0, 3'd0, 3'd7, 1'b0, 8'h5A, 1'b0, 1'b1, 0);
    issue(FnShl, 8'h80, 8'h00, 8'h00, 1'b0, 3'd1, 3'd7, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    issue(FnShr, 8'h02, 8'h00, 8'h00, 1'b0, 3'd1, 3'd7, 1'b0, 8'h01, 1'b0, 1'b0, 0);

    // Store: address computed from immediate, r2 forwarded as data
    issue(FnAdd, 8'h10, 8'hAA, 8'h04, 1'b1, 3'd0, 3'd7, 1'b1, 8'h14, 1'b0, 1'b0, 0);

    // Flush on the 3rd cycle of SHL sc=7
    issue(FnAdd, 8'h80, 8'h80, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    bus.in_valid        = 1'b1;
    bus.alu_function    = FnShl;
    bus.r1              = 8'h01;
    bus.sc              = 3'd7;
    bus.dest            = 3'd2;
    bus.alu_input_b_sel = 1'b0;
    bus.dm_mem_write    = 1'b0;
    #1 check("flush_cyc1_busy", 32'(bus.ex_busy), 1);
    @(posedge clk);
    #1 check("flush_cyc2_busy", 32'(bus.ex_busy), 1);
    @(posedge clk);
    #1 check("flush_cyc3_busy", 32'(bus.ex_busy), 1);
    bus.flush = 1'b1;
    #1 check("flush_busy_drop", 32'(bus.ex_busy), 0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 0);
    check("flush_flag_z", 32'(bus.flag_z), 1);
    check("flush_flag_c", 32'(bus.flag_c), 1);
    check("flush_idle_busy", 32'(bus.ex_busy), 0);
    issue(FnAdd, 8'h01, 8'h01, 8'h00, 1'b0, 3'd0, 3'd3, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    // Flush kills a single-cycle ADD that would have set Z and C
    bus.in_valid     = 1'b1;
    bus.alu_function = FnAdd;
    bus.r1           = 8'hFF;
    bus.r2           = 8'h01;
    bus.flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_out_valid", 32'(bus.out_valid), 0);
    check("kill_flag_z", 32'(bus.flag_z), 0);
    check("kill_flag_c", 32'(bus.flag_c), 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined datapath.
- Consumes the decoded operand bundle from the ID/EX pipeline register and performs the ALU or shift operation.
- Drives the EX/MEM pipeline register and a Z/C flag register.
- Shifts are multi-cycle (one bit per cycle); the block stalls the upstream pipeline with ex_busy while a shift is in progress.

Parameters:
- WIDTH, 8, datapath width of operands and result.
- REGW, 3, register-address / shift-count width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- r1  in  WIDTH  operand A from ID/EX.
- r2  in  WIDTH  register operand B; also the store data.
- const_disp  in  WIDTH  immediate/displacement operand.
- sc  in  REGW  shift count.
- dest  in  REGW  destination register.
- alu_function  in  3  operation select.
- alu_input_b_sel  in  1  1 selects const_disp as B, 0 selects r2.
- dm_mem_write  in  1  instruction is a store.
- flush  in  1  synchronous kill from branch resolution.
- ex_busy  out  1  upstream must hold ID/EX and not advance.
- out_valid  out  1  EX/MEM entry valid.
- out_result  out  WIDTH  registered ALU/shift result (memory address for stores).
- out_store_data  out  WIDTH  registered r2.
- out_dest  out  REGW  registered dest.
- out_mem_write  out  1  registered in_valid & dm_mem_write.
- out_reg_write  out  1  registered in_valid & ~dm_mem_write.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs and internal state go to 0: state IDLE, shift accumulator 0, count 0.
  - ex_busy=0, out_valid=0.
  - Reset mid-shift aborts the shift; nothing is committed.
- Operand selection: A=r1; B = alu_input_b_sel ? const_disp : r2.
- alu_function encoding:
  - 000 ADD: A+B, C = carry-out.
  - 001 SUB: A-B, C = 1 when A>=B (no borrow).
  - 010 AND, 011 OR, 100 XOR: C cleared.
  - 101 SHL: A shifted left by sc, zero fill.
  - 110 SHR: A shifted right logically by sc, zero fill.
  - 111 PASS: result = B; flags unchanged.
- Results are WIDTH bits, modulo 2^WIDTH.
- Flags update only on a committed valid instruction.
  - Z = (result==0) for every op except PASS.
  - For shifts, C = the last bit shifted out; sc=0 leaves C unchanged.
- Single-cycle path: state IDLE, in_valid=1, and either a non-shift op or a shift with sc<=1.
  - ex_busy=0.
  - At the edge, the EX/MEM register loads the result, out_valid<=1, and flags update.
- Multi-cycle shift, sc=N>=2 (state machine IDLE / SHIFT):
  - IDLE cycle: ex_busy=1 combinationally. At the edge, acc<=A shifted by 1, cnt<=N-1, state<=SHIFT, out_valid<=0.
  - SHIFT with cnt>1: ex_busy=1. At the edge, acc shifts by 1, cnt decrements, out_valid<=0.
  - SHIFT with cnt==1: ex_busy=0. At the edge, EX/MEM loads acc shifted by 1, out_valid<=1, flags update, state<=IDLE.
  - Total occupancy is N cycles with N-1 bubble cycles; the commit lands at the end of cycle N.
  - Upstream holds all inputs stable while ex_busy=1. The block uses its captured acc, not r1, after the first cycle.
- in_valid=0: EX/MEM loads a bubble (out_valid<=0, out_mem_write<=0, out_reg_write<=0); flags hold.
- flush=1 at an edge:
  - out_valid, out_mem_write and out_reg_write <= 0; flags hold.
  - State <= IDLE, cnt <= 0.
  - ex_busy is forced to 0 in the same cycle.
  - Flush has priority over every commit or shift step.
- A back-to-back instruction after the shift commit is accepted in the very next cycle with no extra bubble.

Test Plan:
1. Reset with rst=0 mid-operation → all outputs 0, ex_busy=0. Release, then ADD r1=0xF0, r2=0x20, bsel=0 → next cycle out_result=0x10, flag_c=1, flag_z=0, out_valid=1, out_reg_write=1.
2. SUB r1=0x05, const_disp=0x05, bsel=1 → out_result=0x00, flag_z=1, flag_c=1. Then SUB 0x03-0x04 → 0xFF, Z=0, C=0.
3. SHL r1=0x81, sc=3, held stable → ex_busy=1 for 2 cycles with out_valid=0. Cycle 3 commits out_result=0x08, flag_c=0. The following ADD commits the next cycle.
4. SHR r1=0x03, sc=2 → out_result=0x00, Z=1, C=1 after 2 cycles. Then SHL with sc=0 → single cycle, result=A, C unchanged.
5. Store (dm_mem_write=1) ADD r1=0x10, const_disp=0x04, bsel=1, r2=0xAA → out_result=0x14, out_store_data=0xAA, out_mem_write=1, out_reg_write=0.
6. SHL sc=7 with flush=1 on its 3rd cycle → ex_busy drops immediately, out_valid=0, flags unchanged, state IDLE. The next ADD completes in 1 cycle.
